// File: rtl/decode_bypass_unit.sv
// Decode-stage early resolution of register-indirect JMP/CALL: waits out in-flight
// writers of R[rb], forwards the target from M/Wb and issues a one-cycle PC redirect.
module decode_bypass_unit #(
    parameter logic [3:0] JOP     = 4'hB,
    parameter logic [1:0] SP_ADDR = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] IR,
    input  logic       reg_sf1,
    input  logic [7:0] rd_b_rf,
    input  logic       stall_in,
    input  logic       branch_ex,
    input  logic       rw_ex,
    input  logic       sw1_ex,
    input  logic       sm2_ex,
    input  logic       sw2_ex,
    input  logic [1:0] ra_ex,
    input  logic [1:0] rb_ex,
    input  logic [1:0] sp_ex,
    input  logic       rw_m,
    input  logic       sw1_m,
    input  logic       sm2_m,
    input  logic       sw2_m,
    input  logic [1:0] ra_m,
    input  logic [1:0] rb_m,
    input  logic [1:0] sp_m,
    input  logic [7:0] res_m,
    input  logic       rw_wb,
    input  logic       sw1_wb,
    input  logic       sw2_wb,
    input  logic [1:0] ra_wb,
    input  logic [1:0] rb_wb,
    input  logic [1:0] sp_wb,
    input  logic [7:0] dataout_wb,
    input  logic [7:0] data_to_cpu,
    output logic [7:0] reg_rb_d,
    output logic       decode_jump,
    output logic       flush_decode,
    output logic       stall_bypass,
    output logic       bypass_decode_done
);

    typedef enum logic [1:0] {StIdle, StWait, StRedirect} state_e;

    state_e     state_q, state_d;
    logic [1:0] wcnt_q, wcnt_d;
    logic [7:0] tgt_q, tgt_d;
    logic       flushed_q, flushed_d;

    logic [1:0] rb_idx;
    logic [1:0] dst_ex, dst_m, dst_wb;
    logic       ex_match, m_match, wb_match;
    logic       jvalid;
    logic [7:0] operand;

    // JMP and CALL resolve identically; the CALL bit is only for the control unit.
    logic unused_call_bit;
    assign unused_call_bit = IR[2];

    assign rb_idx = IR[1:0];
    assign dst_ex = sw1_ex ? rb_ex : ra_ex;
    assign dst_m  = sw1_m ? rb_m : ra_m;
    assign dst_wb = sw1_wb ? rb_wb : ra_wb;

    assign ex_match = (rw_ex && dst_ex == rb_idx) || (sp_ex != 2'b00 && rb_idx == SP_ADDR);
    assign m_match  = (rw_m && dst_m == rb_idx) || (sp_m != 2'b00 && rb_idx == SP_ADDR);
    assign wb_match = (rw_wb && dst_wb == rb_idx) || (sp_wb != 2'b00 && rb_idx == SP_ADDR);

    // The IR word right after a redirect is the flushed wrong-path fetch.
    assign jvalid = !reg_sf1 && IR[7:4] == JOP && !IR[3] && !flushed_q;

    always_comb begin
        if (m_match && !sm2_m && !sw2_m) begin
            operand = res_m;
        end else if (wb_match) begin
            operand = sw2_wb ? data_to_cpu : dataout_wb;
        end else begin
            operand = rd_b_rf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wcnt_q    <= 2'd0;
            tgt_q     <= 8'h00;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            tgt_q     <= tgt_d;
            flushed_q <= flushed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        tgt_d     = tgt_q;
        flushed_d = flushed_q;
        if (branch_ex) begin
            state_d   = StIdle;
            wcnt_d    = 2'd0;
            flushed_d = 1'b0;
        end else if (!stall_in) begin
            flushed_d = (state_q == StRedirect);
            unique case (state_q)
                StIdle: begin
                    if (jvalid) begin
                        if (ex_match) begin
                            wcnt_d  = (sm2_ex || sw2_ex) ? 2'd2 : 2'd1;
                            state_d = StWait;
                        end else begin
                            tgt_d   = operand;
                            state_d = StRedirect;
                        end
                    end
                end
                StWait: begin
                    if (wcnt_q > 2'd1) begin
                        wcnt_d = wcnt_q - 2'd1;
                    end else if (m_match && sm2_m) begin
                        wcnt_d = 2'd1;
                    end else begin
                        wcnt_d  = 2'd0;
                        tgt_d   = operand;
                        state_d = StRedirect;
                    end
                end
                StRedirect: state_d = StIdle;
                default:    state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        stall_bypass = 1'b0;
        decode_jump  = 1'b0;
        flush_decode = 1'b0;
        reg_rb_d     = rd_b_rf;
        unique case (state_q)
            StIdle: stall_bypass = jvalid;
            StWait: stall_bypass = 1'b1;
            StRedirect: begin
                reg_rb_d     = tgt_q;
                decode_jump  = !stall_in;
                flush_decode = !stall_in;
            end
            default: stall_bypass = 1'b0;
        endcase
        if (branch_ex) begin
            stall_bypass = 1'b0;
            decode_jump  = 1'b0;
            flush_decode = 1'b0;
        end
    end

    assign bypass_decode_done = !stall_bypass;

endmodule

// File: tb/tb_decode_bypass_unit.sv
// Directed bench for decode_bypass_unit: hazard-free, ALU/load/IN/SP producers,
// branch kill, stall during redirect and reset mid-wait.
module tb_decode_bypass_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] IR;
    logic       reg_sf1;
    logic [7:0] rd_b_rf;
    logic       stall_in, branch_ex;
    logic       rw_ex, sw1_ex, sm2_ex, sw2_ex;
    logic [1:0] ra_ex, rb_ex, sp_ex;
    logic       rw_m, sw1_m, sm2_m, sw2_m;
    logic [1:0] ra_m, rb_m, sp_m;
    logic [7:0] res_m;
    logic       rw_wb, sw1_wb, sw2_wb;
    logic [1:0] ra_wb, rb_wb, sp_wb;
    logic [7:0] dataout_wb, data_to_cpu;
    logic [7:0] reg_rb_d;
    logic       decode_jump, flush_decode, stall_bypass, bypass_decode_done;

    int checks = 0;
    int errors = 0;

    decode_bypass_unit dut (
        .clk                (clk),
        .rst                (rst),
        .IR                 (IR),
        .reg_sf1            (reg_sf1),
        .rd_b_rf            (rd_b_rf),
        .stall_in           (stall_in),
        .branch_ex          (branch_ex),
        .rw_ex              (rw_ex),
        .sw1_ex             (sw1_ex),
        .sm2_ex             (sm2_ex),
        .sw2_ex             (sw2_ex),
        .ra_ex              (ra_ex),
        .rb_ex              (rb_ex),
        .sp_ex              (sp_ex),
        .rw_m               (rw_m),
        .sw1_m              (sw1_m),
        .sm2_m              (sm2_m),
        .sw2_m              (sw2_m),
        .ra_m               (ra_m),
        .rb_m               (rb_m),
        .sp_m               (sp_m),
        .res_m              (res_m),
        .rw_wb              (rw_wb),
        .sw1_wb             (sw1_wb),
        .sw2_wb             (sw2_wb),
        .ra_wb              (ra_wb),
        .rb_wb              (rb_wb),
        .sp_wb              (sp_wb),
        .dataout_wb         (dataout_wb),
        .data_to_cpu        (data_to_cpu),
        .reg_rb_d           (reg_rb_d),
        .decode_jump        (decode_jump),
        .flush_decode       (flush_decode),
        .stall_bypass       (stall_bypass),
        .bypass_decode_done (bypass_decode_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks every output; bypass_decode_done is expected to be the inverse of stall.
    task automatic chk_out(input string tag, input logic dj, input logic fl, input logic sb,
                           input logic [7:0] rb);
        #1;
        chk({tag, ".decode_jump"}, {7'd0, decode_jump}, {7'd0, dj});
        chk({tag, ".flush_decode"}, {7'd0, flush_decode}, {7'd0, fl});
        chk({tag, ".stall_bypass"}, {7'd0, stall_bypass}, {7'd0, sb});
        chk({tag, ".done"}, {7'd0, bypass_decode_done}, {7'd0, !sb});
        chk({tag, ".reg_rb_d"}, reg_rb_d, rb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        IR = 8'h00; reg_sf1 = 1'b0; rd_b_rf = 8'h00; stall_in = 1'b0; branch_ex = 1'b0;
        rw_ex = 1'b0; sw1_ex = 1'b0; sm2_ex = 1'b0; sw2_ex = 1'b0;
        ra_ex = 2'd0; rb_ex = 2'd0; sp_ex = 2'd0;
        rw_m = 1'b0; sw1_m = 1'b0; sm2_m = 1'b0; sw2_m = 1'b0;
        ra_m = 2'd0; rb_m = 2'd0; sp_m = 2'd0; res_m = 8'h00;
        rw_wb = 1'b0; sw1_wb = 1'b0; sw2_wb = 1'b0;
        ra_wb = 2'd0; rb_wb = 2'd0; sp_wb = 2'd0;
        dataout_wb = 8'h00; data_to_cpu = 8'h00;
    endtask

    task automatic idle(input int n);
        clear();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        clear();
        rst = 1'b1;
        rd_b_rf = 8'h11;
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 8'h11);
        rst = 1'b0;
        idle(1);

        // Non-jump words never stall
        IR = 8'hB1; reg_sf1 = 1'b1; rd_b_rf = 8'h22;
        chk_out("sf1_word", 1'b0, 1'b0, 1'b0, 8'h22);
        reg_sf1 = 1'b0; IR = 8'hB9;
        chk_out("ir3_set", 1'b0, 1'b0, 1'b0, 8'h22);
        IR = 8'hA1;
        chk_out("other_op", 1'b0, 1'b0, 1'b0, 8'h22);
        idle(1);

        // No hazard: target straight from the register file
        IR = 8'hB1; rd_b_rf = 8'h40;
        chk_out("nohaz.c0", 1'b0, 1'b0, 1'b1, 8'h40);
        tick();
        IR = 8'h00; rd_b_rf = 8'h99;
        chk_out("nohaz.c1", 1'b1, 1'b1, 1'b0, 8'h40);
        tick();
        chk_out("nohaz.c2", 1'b0, 1'b0, 1'b0, 8'h99);
        idle(2);

        // ALU producer of R2 in Ex: one wait, target from res_m
        IR = 8'hB2; rd_b_rf = 8'h01; rw_ex = 1'b1; ra_ex = 2'd2;
        chk_out("alu.c0", 1'b0, 1'b0, 1'b1, 8'h01);
        tick();
        clear(); IR = 8'hB2; rd_b_rf = 8'h01; rw_m = 1'b1; ra_m = 2'd2; res_m = 8'h5A;
        chk_out("alu.c1", 1'b0, 1'b0, 1'b1, 8'h01);
        tick();
        clear(); rw_wb = 1'b1; ra_wb = 2'd2; dataout_wb = 8'h5A; rd_b_rf = 8'h02;
        chk_out("alu.c2", 1'b1, 1'b1, 1'b0, 8'h5A);
        idle(2);

        // Load producer: two waits, target from dataout_wb
        IR = 8'hB2; rd_b_rf = 8'h01; rw_ex = 1'b1; ra_ex = 2'd2; sm2_ex = 1'b1;
        chk_out("ld.c0", 1'b0, 1'b0, 1'b1, 8'h01);
        tick();
        clear(); IR = 8'hB2; rd_b_rf = 8'h01; rw_m = 1'b1; ra_m = 2'd2; sm2_m = 1'b1;
        res_m = 8'hEE;
        chk_out("ld.c1", 1'b0, 1'b0, 1'b1, 8'h01);
        tick();
        clear(); IR = 8'hB2; rd_b_rf = 8'h01; rw_wb = 1'b1; ra_wb = 2'd2; dataout_wb = 8'hC3;
        chk_out("ld.c2", 1'b0, 1'b0, 1'b1, 8'h01);
        tick();
        clear(); dataout_wb = 8'h5F;
        chk_out("ld.c3", 1'b1, 1'b1, 1'b0, 8'hC3);
        idle(2);

        // IN producer: two waits, target from data_to_cpu
        IR = 8'hB2; rw_ex = 1'b1; ra_ex = 2'd2; sw2_ex = 1'b1;
        chk_out("in.c0", 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        clear(); IR = 8'hB2; rw_m = 1'b1; ra_m = 2'd2; sw2_m = 1'b1; res_m = 8'hEE;
        chk_out("in.c1", 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        clear(); IR = 8'hB2; rw_wb = 1'b1; ra_wb = 2'd2; sw2_wb = 1'b1;
        data_to_cpu = 8'h77; dataout_wb = 8'h12;
        chk_out("in.c2", 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        clear();
        chk_out("in.c3", 1'b1, 1'b1, 1'b0, 8'h77);
        idle(2);

        // Branch in Ex kills the pending jump while waiting
        IR = 8'hB2; rw_ex = 1'b1; ra_ex = 2'd2; rd_b_rf = 8'h33;
        tick();
        clear(); IR = 8'hB2; rd_b_rf = 8'h33; branch_ex = 1'b1; rw_m = 1'b1; ra_m = 2'd2;
        chk_out("kill.c1", 1'b0, 1'b0, 1'b0, 8'h33);
        tick();
        clear(); rd_b_rf = 8'h34;
        chk_out("kill.c2", 1'b0, 1'b0, 1'b0, 8'h34);
        tick();
        chk_out("kill.c3", 1'b0, 1'b0, 1'b0, 8'h34);
        idle(2);

        // stall_in held two cycles during REDIRECT
        IR = 8'hB1; rd_b_rf = 8'h3C;
        tick();
        IR = 8'h00; rd_b_rf = 8'h00; stall_in = 1'b1;
        chk_out("stl.c1", 1'b0, 1'b0, 1'b0, 8'h3C);
        tick();
        chk_out("stl.c2", 1'b0, 1'b0, 1'b0, 8'h3C);
        tick();
        stall_in = 1'b0;
        chk_out("stl.c3", 1'b1, 1'b1, 1'b0, 8'h3C);
        tick();
        chk_out("stl.c4", 1'b0, 1'b0, 1'b0, 8'h00);
        idle(2);

        // CALL through SP while PUSH is in Ex
        IR = 8'hB7; sp_ex = 2'b01; rd_b_rf = 8'hFF;
        chk_out("sp.c0", 1'b0, 1'b0, 1'b1, 8'hFF);
        tick();
        clear(); IR = 8'hB7; rd_b_rf = 8'hFF; sp_m = 2'b01; res_m = 8'hFE;
        chk_out("sp.c1", 1'b0, 1'b0, 1'b1, 8'hFF);
        tick();
        clear();
        chk_out("sp.c2", 1'b1, 1'b1, 1'b0, 8'hFE);
        idle(2);

        // Reset pulsed mid-WAIT
        IR = 8'hB2; rw_ex = 1'b1; ra_ex = 2'd2; sm2_ex = 1'b1;
        tick();
        clear(); IR = 8'hB2; rst = 1'b1; rd_b_rf = 8'h45;
        chk_out("rstw.c1", 1'b0, 1'b0, 1'b1, 8'h45);
        tick();
        rst = 1'b0; IR = 8'h00;
        chk_out("rstw.c2", 1'b0, 1'b0, 1'b0, 8'h45);
        tick();
        chk_out("rstw.c3", 1'b0, 1'b0, 1'b0, 8'h45);
        tick();
        chk_out("rstw.c4", 1'b0, 1'b0, 1'b0, 8'h45);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
